load_store_unit: RTL and testbench

Core-side load/store unit driving port B of the dual-port BRAM main memory. Accepts one byte, halfword or word load or store per request, generates byte enables and lane-replicated write data, and captures the one-cycle BRAM read data. Sign- or zero-extends load results and faults misaligned or out-of-range accesses without touching memory. Sits between the core's memory stage and the memory block; port A (instruction fetch) is unaffected.

---
 rtl/lsu_pkg.sv | 10 +
 rtl/lsu_align.sv | 21 ++
 rtl/load_store_unit.sv | 85 ++++++++
 tb/tb_load_store_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and byte-enable helper for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_RSVD} lsu_size_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} lsu_state_t;
  function automatic logic [3:0] byte_en(lsu_size_t size, logic [1:0] off);
    return size == SIZE_B ? 4'b0001 << off :
           size == SIZE_H ? (off[1] ? 4'b1100 : 4'b0011) :
           size == SIZE_W ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication and load lane extract with sign/zero extension
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_t   w_size,
  input  logic [31:0] wdata,
  output logic [31:0] lane_wdata,
  input  lsu_size_t   r_size,
  input  logic        r_unsigned,
  input  logic [1:0]  r_off,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);
  logic [31:0] sh;
  always_comb begin
    lane_wdata = w_size == SIZE_B ? {4{wdata[7:0]}} : w_size == SIZE_H ? {2{wdata[15:0]}} : wdata;
    sh = rdata >> {r_off, 3'b000};
    load_data = r_size == SIZE_B ? {{24{~r_unsigned & sh[7]}}, sh[7:0]} :
                r_size == SIZE_H ? {{16{~r_unsigned & sh[15]}}, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for BRAM port B, fixed 2-cycle latency
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 8192,
  localparam int AW = $clog2(MEM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_fault,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [3:0]    mem_data_en,
  output logic          mem_write_en
);
  lsu_state_t state, state_d;
  lsu_size_t size, size_q;
  logic [1:0] off, off_q;
  logic accept, fault, drive, write_q, unsigned_q, fault_q;
  logic [31:0] lane_wdata, load_data;
  lsu_align u_align (
    .w_size(size),
    .wdata(req_wdata),
    .lane_wdata(lane_wdata),
    .r_size(size_q),
    .r_unsigned(unsigned_q),
    .r_off(off_q),
    .rdata(mem_rdata),
    .load_data(load_data)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_d;
  always_comb
    state_d = state == WAIT ? RESP : accept ? WAIT : IDLE;
  always_comb begin
    req_ready = ~rst & (state != WAIT);
    resp_valid = ~rst & (state == RESP);
  end
  // memory is only driven for a fault-free request in its accept cycle
  always_comb begin
    size = lsu_size_t'(req_size);
    off = req_addr[1:0];
    fault = (req_addr >= 32'(MEM_SIZE)) | (size == SIZE_RSVD) |
            (size == SIZE_H & off[0]) | (size == SIZE_W & off != 2'b00);
    accept = req_valid & req_ready;
    drive = accept & ~fault;
    mem_addr = drive ? req_addr[AW-1:0] : '0;
    mem_data_en = drive ? byte_en(size, off) : 4'b0000;
    mem_write_en = drive & req_write;
    mem_wdata = drive ? lane_wdata : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q <= 1'b0;
      size_q <= SIZE_B;
      unsigned_q <= 1'b0;
      off_q <= 2'b00;
      fault_q <= 1'b0;
      resp_rdata <= 32'h0;
      resp_fault <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        size_q <= size;
        unsigned_q <= req_unsigned;
        off_q <= off;
        fault_q <= fault;
      end
      if (state == WAIT) begin
        resp_rdata <= (write_q | fault_q) ? 32'h0 : load_data;
        resp_fault <= fault_q;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus random requests against a byte-array memory model
module tb_load_store_unit;
  localparam int MEM_SIZE = 8192;
  logic clk, rst, req_valid, req_ready, req_write, req_unsigned;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_wdata, mem_rdata;
  logic resp_valid, resp_fault, mem_write_en;
  logic [12:0] mem_addr;
  logic [3:0] mem_data_en;
  logic [7:0] bram [MEM_SIZE];
  logic [7:0] model [MEM_SIZE];
  logic preload;
  int checks, errors;
  logic [31:0] rd, v;
  load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_en(mem_data_en),
    .mem_write_en(mem_write_en)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // BRAM port B: registered read of the old word, byte-enabled write
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEM_SIZE; i++) bram[i] <= model[i];
    end else begin
      mem_rdata <= {bram[{mem_addr[12:2], 2'd3}], bram[{mem_addr[12:2], 2'd2}],
                    bram[{mem_addr[12:2], 2'd1}], bram[{mem_addr[12:2], 2'd0}]};
      for (int i = 0; i < 4; i++)
        if (mem_write_en && mem_data_en[i]) bram[{mem_addr[12:2], 2'(i)}] <= mem_wdata[8*i+:8];
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
    return a >= 32'(MEM_SIZE) || sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction
  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
    logic [31:0] r;
    int n;
    n = nbytes(sz);
    r = 0;
    for (int k = 0; k < n; k++) r = r | (32'(model[int'(a) + k]) << (8 * k));
    if (n < 4 && !u && r[8*n-1]) r = r | (32'hFFFFFFFF << (8 * n));
    return r;
  endfunction
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic f;
    int n, t;
    logic [31:0] exp_r, exp_wd;
    f = ref_fault(sz, a);
    n = nbytes(sz);
    exp_r = (f || w) ? 32'h0 : ref_load(sz, u, a);
    exp_wd = 0;
    for (int i = 0; i < 4; i++) exp_wd[8*i+:8] = wd[8*(i % n)+:8];
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    #1;
    t = 0;
    while (!req_ready && t < 8) begin @(posedge clk); #1; t++; end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'h1);
    check("data_en", 32'(mem_data_en), f ? 32'h0 : 32'(((1 << n) - 1) << a[1:0]));
    check("write_en", 32'(mem_write_en), 32'(w & ~f));
    check("mem_addr", 32'(mem_addr), f ? 32'h0 : 32'(a[12:0]));
    if (!f) check("mem_wdata", mem_wdata, exp_wd);
    if (!f && w) for (int k = 0; k < n; k++) model[int'(a) + k] = wd[8*k+:8];
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait_ready", 32'(req_ready), 32'h0);
    check("wait_rvalid", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    check("resp_valid", 32'(resp_valid), 32'h1);
    check("resp_fault", 32'(resp_fault), 32'(f));
    check("resp_rdata", resp_rdata, exp_r);
    got = resp_rdata;
  endtask
  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < MEM_SIZE; i++) model[i] = 8'($urandom);
    {model[19], model[18], model[17], model[16]} = 32'h8899AABB;
    preload = 1'b1;
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    preload = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_write_en", 32'(mem_write_en), 32'h0);
    check("rst_data_en", 32'(mem_data_en), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_rvalid", 32'(resp_valid), 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_fault", 32'(resp_fault), 32'h0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    do_req(0, 2, 0, 32'h10, 0, rd); check("lw_10", rd, 32'h8899AABB);
    do_req(0, 0, 0, 32'h13, 0, rd); check("lb_13", rd, 32'hFFFFFF88);
    do_req(0, 0, 1, 32'h13, 0, rd); check("lbu_13", rd, 32'h00000088);
    do_req(0, 1, 0, 32'h12, 0, rd); check("lh_12", rd, 32'hFFFF8899);
    do_req(0, 1, 1, 32'h10, 0, rd); check("lhu_10", rd, 32'h0000AABB);
    do_req(1, 0, 0, 32'h11, 32'h12345677, rd);
    do_req(0, 2, 0, 32'h10, 0, rd); check("lw_after_sb", rd, 32'h889977BB);
    do_req(0, 1, 0, 32'h11, 0, rd);
    do_req(1, 2, 0, 32'h12, 32'hCAFEF00D, rd);
    do_req(0, 2, 0, 32'h2000, 0, rd);
    do_req(0, 3, 0, 32'h10, 0, rd);
    // back-to-back: valid held high across two loads
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    #1 check("b2b_c0_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_size = 2'd0; req_addr = 32'h12;
    #1 check("b2b_c1_ready", 32'(req_ready), 32'h0);
    check("b2b_c1_rvalid", 32'(resp_valid), 32'h0);
    @(negedge clk); #1;
    check("b2b_c2_ready", 32'(req_ready), 32'h1);
    check("b2b_c2_rvalid", 32'(resp_valid), 32'h1);
    check("b2b_c2_rdata", resp_rdata, ref_load(2, 0, 32'h10));
    @(negedge clk);
    req_valid = 1'b0;
    #1 check("b2b_c3_ready", 32'(req_ready), 32'h0);
    check("b2b_c3_rvalid", 32'(resp_valid), 32'h0);
    @(negedge clk); #1;
    check("b2b_c4_rvalid", 32'(resp_valid), 32'h1);
    check("b2b_c4_rdata", resp_rdata, ref_load(0, 0, 32'h12));
    // reset during WAIT drops the response but keeps the committed store
    v = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = v;
    #1 check("rstw_ready", 32'(req_ready), 32'h1);
    {model[35], model[34], model[33], model[32]} = v;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1 check("rstw_rvalid_in_rst", 32'(resp_valid), 32'h0);
    rst = 1'b0;
    #1 check("rstw_ready_after", 32'(req_ready), 32'h1);
    check("rstw_rvalid_after", 32'(resp_valid), 32'h0);
    @(negedge clk); #1;
    check("rstw_rvalid_later", 32'(resp_valid), 32'h0);
    do_req(0, 2, 0, 32'h20, 0, rd); check("lw_after_rst", rd, v);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      a = r == 0 ? 32'h2000 + 32'($urandom_range(0, 15)) : r == 1 ? 32'($urandom) : 32'($urandom_range(0, 255));
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, 32'($urandom), rd);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
